// File: rtl/sign_ext_pkg.sv
// Shared widths, saturation constants and the S1 payload type for the
// 16-to-9 bit signed narrowing path.
package sign_ext_pkg;

   localparam int unsigned IN_W  = 16;
   localparam int unsigned OUT_W = 9;
   localparam int unsigned CNT_W = 8;

   // Extremes of the 9-bit signed range
   localparam logic [OUT_W-1:0] SAT_MAX9 = 9'h0FF;
   localparam logic [OUT_W-1:0] SAT_MIN9 = 9'h100;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic             ovf;
   } s1_payload_t;

endpackage

// File: rtl/narrow_range_check.sv
// Combinational range check: decides whether a 16-bit value fits a 9-bit
// signed field and produces the narrowed (saturated or wrapped) result.
module narrow_range_check
   import sign_ext_pkg::*;
(
   input  logic [IN_W-1:0]  in_data,
   input  logic             sat_en,
   output logic [OUT_W-1:0] data,
   output logic             ovf
);

   logic [IN_W-OUT_W:0] hi_bits;
   logic                fits;

   // Value fits when every bit from the 9-bit sign position upward agrees
   assign hi_bits = in_data[IN_W-1:OUT_W-1];
   assign fits    = (&hi_bits) | ~(|hi_bits);

   // Select narrowed value and overflow flag
   always_comb begin
      data = in_data[OUT_W-1:0];
      ovf  = 1'b0;
      if (!fits) begin
         ovf = 1'b1;
         if (sat_en) begin
            data = in_data[IN_W-1] ? SAT_MIN9 : SAT_MAX9;
         end
      end
   end

endmodule

// File: rtl/sign_narrow_16to9.sv
// Two-stage valid/ready narrowing pipeline with per-item overflow flag,
// sticky overflow flag and saturating overflow counter.
module sign_narrow_16to9
   import sign_ext_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             sat_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf,
   input  logic             ovf_clr,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] ovf_count
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic [OUT_W-1:0] chk_data;
   logic             chk_ovf;

   logic             s1_valid_q, s1_valid_d;
   s1_payload_t      s1_pay_q, s1_pay_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic             out_ovf_q, out_ovf_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             s2_free;
   logic             s1_free;
   logic             ovf_evt;

   narrow_range_check u_check (
      .in_data (in_data),
      .sat_en  (sat_en),
      .data    (chk_data),
      .ovf     (chk_ovf)
   );

   // Flow control: a stage can take new data if empty or its content leaves this cycle
   always_comb begin
      s2_free  = !out_valid_q || out_ready;
      s1_free  = !s1_valid_q || s2_free;
      in_ready = s1_free;
      ovf_evt  = out_valid_q && out_ready && out_ovf_q;
   end

   // S1 next state: load a new item when S1 advances
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_pay_d   = s1_pay_q;
      if (s1_free) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_pay_d.data = chk_data;
            s1_pay_d.ovf  = chk_ovf;
         end
      end
   end

   // S2 next state: take S1 content when the output register is free
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      if (s2_free) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = s1_pay_q.data;
            out_ovf_d  = s1_pay_q.ovf;
         end
      end
   end

   // Overflow statistics: clear takes effect first, then the transfer event
   always_comb begin
      sticky_d = ovf_clr ? 1'b0 : sticky_q;
      cnt_d    = ovf_clr ? '0 : cnt_q;
      if (ovf_evt) begin
         sticky_d = 1'b1;
         if (cnt_d != CntMax) begin
            cnt_d = cnt_d + CNT_W'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_pay_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_pay_q    <= s1_pay_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_ovf    = out_ovf_q;
   assign ovf_sticky = sticky_q;
   assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_sign_narrow_16to9.sv
// Bench for sign_narrow_16to9: directed vectors with literal expectations plus
// an arithmetic reference model checked on every output transfer.
module tb_sign_narrow_16to9;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        sat_en;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  out_data;
   logic        out_ovf;
   logic        ovf_clr;
   logic        ovf_sticky;
   logic [7:0]  ovf_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] orig;
      logic [8:0]  d;
      logic        o;
   } exp_t;

   exp_t exp_q[$];
   int   m_cnt    = 0;
   bit   m_sticky = 0;
   bit   held     = 0;
   logic [8:0] held_data;
   logic       held_ovf;

   sign_narrow_16to9 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .sat_en     (sat_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ovf    (out_ovf),
      .ovf_clr    (ovf_clr),
      .ovf_sticky (ovf_sticky),
      .ovf_count  (ovf_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: interpret as a signed integer and test against [-256, 255]
   function automatic exp_t model(input logic [15:0] d, input logic sat);
      exp_t e;
      int   v;
      v      = int'($signed(d));
      e.orig = d;
      if (v >= -256 && v <= 255) begin
         e.d = d[8:0];
         e.o = 1'b0;
      end else begin
         e.o = 1'b1;
         if (sat) e.d = (v < 0) ? 9'h100 : 9'h0FF;
         else     e.d = d[8:0];
      end
      return e;
   endfunction

   // Compare process: sampled on the falling edge, predicts the next rising edge
   always @(negedge clk) begin
      exp_t e;
      bit   ev;
      if (!rst_n) begin
         exp_q.delete();
         m_cnt    = 0;
         m_sticky = 0;
         held     = 0;
      end else begin
         chk("sticky", 32'(ovf_sticky), 32'(m_sticky));
         chk("count", 32'(ovf_count), 32'(m_cnt));
         if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(held_data));
            chk("hold_ovf", 32'(out_ovf), 32'(held_ovf));
         end
         ev = 0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual=%0h required=none at %0t", out_data, $time);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(out_data), 32'(e.d));
               chk("out_ovf", 32'(out_ovf), 32'(e.o));
               if (!e.o) chk("roundtrip", 32'({{7{out_data[8]}}, out_data}), 32'(e.orig));
               ev = e.o;
            end
         end
         held      = out_valid && !out_ready;
         held_data = out_data;
         held_ovf  = out_ovf;
         if (in_valid && in_ready) exp_q.push_back(model(in_data, sat_en));
         if (ovf_clr) begin
            m_cnt    = 0;
            m_sticky = 0;
         end
         if (ev) begin
            m_sticky = 1;
            if (m_cnt < 255) m_cnt++;
         end
      end
   end

   // Single item on an empty pipe; checks two-cycle latency and literal result
   task automatic send_one(input logic [15:0] d, input logic s,
                           input logic [8:0] ed, input logic eo, input string name);
      in_valid = 1'b1;
      in_data  = d;
      sat_en   = s;
      chk({name, "_inrdy"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({name, "_lat1"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk({name, "_lat2"}, 32'(out_valid), 32'd1);
      chk({name, "_data"}, 32'(out_data), 32'(ed));
      chk({name, "_ovf"}, 32'(out_ovf), 32'(eo));
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      int cyc;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      sat_en    = 1'b1;
      out_ready = 1'b1;
      ovf_clr   = 1'b0;
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
      chk("rst_sticky", 32'(ovf_sticky), 32'd0);
      chk("rst_count", 32'(ovf_count), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Nominal in-range values
      send_one(16'h00FF, 1'b1, 9'h0FF, 1'b0, "nom_00ff");
      send_one(16'hFF00, 1'b1, 9'h100, 1'b0, "nom_ff00");
      send_one(16'hFFFF, 1'b1, 9'h1FF, 1'b0, "nom_ffff");
      send_one(16'h0000, 1'b1, 9'h000, 1'b0, "nom_0000");

      // Out-of-range values
      send_one(16'h0100, 1'b1, 9'h0FF, 1'b1, "ovf_0100_sat");
      send_one(16'h0100, 1'b0, 9'h100, 1'b1, "ovf_0100_wrap");
      send_one(16'h8000, 1'b1, 9'h100, 1'b1, "ovf_8000_sat");
      idle(2);
      chk("ovf_count_3", 32'(ovf_count), 32'd3);
      chk("ovf_sticky_1", 32'(ovf_sticky), 32'd1);

      // Backpressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0001;
      sat_en    = 1'b1;
      @(posedge clk); #1;
      in_data = 16'h0002;
      chk("bp_rdy_after1", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_data = 16'h0003;
      chk("bp_rdy_after2", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h001);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_rdy_still0", 32'(in_ready), 32'd0);
      chk("bp_data_held", 32'(out_data), 32'h001);
      out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_out2", 32'(out_data), 32'h002);
      @(posedge clk); #1;
      chk("bp_out3", 32'(out_data), 32'h003);
      idle(2);

      // Counter saturation: 300 overflowing items back to back
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr  = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h0100;
      sat_en   = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      idle(4);
      chk("cnt_sat_255", 32'(ovf_count), 32'd255);
      chk("cnt_sat_sticky", 32'(ovf_sticky), 32'd1);

      // Clear coinciding with an overflowing transfer
      send_one(16'h7FFF, 1'b1, 9'h0FF, 1'b1, "clr_item");
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      chk("clr_evt_count", 32'(ovf_count), 32'd1);
      chk("clr_evt_sticky", 32'(ovf_sticky), 32'd1);
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      chk("clr_only_count", 32'(ovf_count), 32'd0);
      chk("clr_only_sticky", 32'(ovf_sticky), 32'd0);

      // Reset with both stages full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0155;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("full_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_data", 32'(out_data), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      chk("post_rst_rdy", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("no_stale", 32'(out_valid), 32'd0);
      end

      // Random stress against the model
      acc = 0;
      cyc = 0;
      while (acc < 10000 && cyc < 40000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         sat_en    = $urandom_range(0, 1);
         ovf_clr   = ($urandom_range(0, 99) == 0);
         case ($urandom_range(0, 3))
            0: in_data = 16'($urandom);
            1: in_data = 16'($urandom_range(0, 511) - 256);
            2: in_data = ($urandom_range(0, 1) ? 16'h00FF : 16'hFF00)
                         + 16'($urandom_range(0, 4)) - 16'd2;
            default: in_data = ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000);
         endcase
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
         cyc++;
      end
      chk("stress_done", 32'(acc), 32'd10000);
      in_valid  = 1'b0;
      ovf_clr   = 1'b0;
      out_ready = 1'b1;
      idle(5);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
